seq_divider16: RTL and testbench

- Multi-cycle unsigned integer divider for the execute stage: the inverse operation of the datapath's carry-lookahead adder/multiplier path.
- Computes quotient and remainder by restoring division, one quotient bit per cycle.
- The trial subtraction is add-with-inverted-B and Cin=1; the carry-out is the no-borrow flag.
- The pipeline stalls on busy and captures results on done.

---
 rtl/seq_divider16.sv | 102 ++++++++++
 tb/tb_seq_divider16.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results
// held until the next accepted start.
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   r, r_sh, r_nxt;
  logic [WIDTH-1:0] q, q_nxt, dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] trial;
  logic             accept, last, unused_rmsb;

  // The partial remainder never reaches 2^WIDTH once restored, so its top
  // bit is shifted out without being looked at.
  assign unused_rmsb = r[WIDTH];

  // Trial subtract as add-with-inverted-divisor; carry-out means no borrow.
  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    trial = {1'b0, r_sh} + {1'b0, ~{1'b0, dvsr}} + (WIDTH+2)'(1);
    if (trial[WIDTH+1]) begin
      r_nxt = trial[WIDTH:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = r_sh;
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CNT_W'(WIDTH-1));
    busy      = (state == RUN);
    done      = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dvsr <= divisor;
        r    <= '0;
        q    <= dividend;
        cnt  <= '0;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed + random bench for seq_divider16; expected results queued at issue
// time and compared when done pulses.
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] q, r, a, b;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy_done_excl", busy && done, 1'b0);
      if (done) begin
        chk("done_has_expect", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          if (!e.dbz) begin
            chk("q*d+r", ({16'd0, quotient} * {16'd0, e.b}) + {16'd0, remainder}, {16'd0, e.a});
            chk("r_lt_d", remainder < e.b, 1'b1);
          end
          last_q = e.q;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b));
  endtask

  task automatic wait_done(input int lat);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= lat + 4 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        n    = i;
      end else if (i < lat) begin
        chk("busy_run", busy, 1'b1);
        chk("result_held", quotient, last_q);
      end
    end
    chk("latency", n, lat);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b);
    issue(a, b, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    wait_done((b == 16'd0) ? 1 : 17);
    if (b == 16'd0) chk("dbz_no_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 16'd0);
    chk("rst_r", remainder, 16'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;

    run(16'd100, 16'd7);
    run(16'hFFFF, 16'd1);
    run(16'hFFFF, 16'hFFFF);
    run(16'd3, 16'd10);
    run(16'd5, 16'd0);
    run(16'd0, 16'd9);

    issue(16'd1000, 16'd3, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    issue(16'd9, 16'd2, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    wait_done(13);
    issue(16'd9, 16'd2, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    wait_done(17);
    @(posedge clk); #1;

    issue(16'd500, 16'd7, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_q = '0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_q", quotient, 16'd0);
    chk("mid_rst_r", remainder, 16'd0);
    repeat (20) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 1'b0);
    end
    @(posedge clk); #1;
    run(16'd500, 16'd7);

    issue(16'd20, 16'd6, 1'b1);
    sb.push_back(model(16'd20, 16'd6));
    @(posedge clk); #1;
    wait_done(17);
    @(posedge clk); #1 start = 1'b0;
    wait_done(17);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run(a, b);
    end

    issue(16'($urandom), 16'($urandom_range(1, 65535)), 1'b1);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_done(17);
      issue(16'($urandom), 16'($urandom_range(1, 65535)), 1'b1);
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(17);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
